// File: rtl/irq_sequencer.sv
// rtl/irq_sequencer.sv - reset/NMI/IRQ sequencer that injects BRK opcodes at instruction boundaries
// Selects the vector, flags hardware sequences and inhibits PC increment while one runs.
module irq_sequencer #(
   parameter int SYNC_STAGES = 2,
   parameter int VEC_W       = 2
) (
   input  logic             ph1,
   input  logic             resetb,
   input  logic [7:0]       mem_data,
   input  logic [7:0]       p,
   input  logic             first_cycle,
   input  logic             int_done,
   input  logic             nmi_b,
   input  logic             irq_b,
   output logic [7:0]       data_out,
   output logic [VEC_W-1:0] vector_sel,
   output logic             int_active,
   output logic             brk_flag
);

   localparam logic [VEC_W-1:0] VEC_IRQ = VEC_W'(0);
   localparam logic [VEC_W-1:0] VEC_NMI = VEC_W'(1);
   localparam logic [VEC_W-1:0] VEC_RST = VEC_W'(2);

   typedef enum logic [1:0] {
      RST_PEND = 2'd0,
      IDLE     = 2'd1,
      ACTIVE   = 2'd2
   } state_t;

   state_t                 r_state;
   logic [SYNC_STAGES-1:0] r_nmi_sync;
   logic [SYNC_STAGES-1:0] r_irq_sync;
   logic [SYNC_STAGES:0]   r_sync_vld;
   logic                   r_nmi_prev;
   logic                   r_nmi_pend;
   logic [VEC_W-1:0]       r_vector_sel;
   logic                   r_int_active;
   logic                   r_brk_flag;

   logic w_nmi_s;
   logic w_irq_s;
   logic w_nmi_edge;
   logic w_irq_req;
   logic w_inject_rst;
   logic w_inject_nmi;
   logic w_inject_irq;
   logic w_inject;
   logic w_unused_p;

   assign w_nmi_s = r_nmi_sync[SYNC_STAGES-1];
   assign w_irq_s = r_irq_sync[SYNC_STAGES-1];

   // Edges are only trusted once real samples fill the chain, so a low nmi_b at reset release is no edge.
   assign w_nmi_edge = r_sync_vld[SYNC_STAGES] & r_nmi_prev & ~w_nmi_s;
   assign w_irq_req  = ~w_irq_s & ~p[2];
   assign w_unused_p = ^{p[7:3], p[1:0]};

   assign w_inject_rst = first_cycle & (r_state == RST_PEND);
   assign w_inject_nmi = first_cycle & (r_state == IDLE) & r_nmi_pend;
   assign w_inject_irq = first_cycle & (r_state == IDLE) & ~r_nmi_pend & w_irq_req;
   assign w_inject     = w_inject_rst | w_inject_nmi | w_inject_irq;

   assign data_out   = w_inject ? 8'h00 : mem_data;
   assign vector_sel = r_vector_sel;
   assign int_active = r_int_active;
   assign brk_flag   = r_brk_flag;

   always_ff @(posedge ph1 or negedge resetb) begin
      if (!resetb) begin
         r_nmi_sync <= '1;
         r_irq_sync <= '1;
         r_sync_vld <= '0;
         r_nmi_prev <= 1'b1;
      end else begin
         r_nmi_sync[0] <= nmi_b;
         r_irq_sync[0] <= irq_b;
         for (int i = 1; i < SYNC_STAGES; i++) begin
            r_nmi_sync[i] <= r_nmi_sync[i-1];
            r_irq_sync[i] <= r_irq_sync[i-1];
         end
         r_sync_vld <= {r_sync_vld[SYNC_STAGES-1:0], 1'b1};
         r_nmi_prev <= w_nmi_s;
      end
   end

   // A fresh edge wins over the clear, so an edge coinciding with an NMI injection stays pending.
   always_ff @(posedge ph1 or negedge resetb) begin
      if (!resetb) begin
         r_nmi_pend <= 1'b0;
      end else if (w_nmi_edge) begin
         r_nmi_pend <= 1'b1;
      end else if (w_inject_nmi) begin
         r_nmi_pend <= 1'b0;
      end
   end

   always_ff @(posedge ph1 or negedge resetb) begin
      if (!resetb) begin
         r_state      <= RST_PEND;
         r_vector_sel <= VEC_RST;
         r_int_active <= 1'b0;
         r_brk_flag   <= 1'b1;
      end else begin
         case (r_state)
            RST_PEND: begin
               if (w_inject_rst) begin
                  r_state      <= ACTIVE;
                  r_vector_sel <= VEC_RST;
                  r_int_active <= 1'b1;
                  r_brk_flag   <= 1'b0;
               end
            end
            IDLE: begin
               if (w_inject_nmi || w_inject_irq) begin
                  r_state      <= ACTIVE;
                  r_vector_sel <= w_inject_nmi ? VEC_NMI : VEC_IRQ;
                  r_int_active <= 1'b1;
                  r_brk_flag   <= 1'b0;
               end
            end
            ACTIVE: begin
               if (int_done) begin
                  r_state      <= IDLE;
                  r_vector_sel <= VEC_IRQ;
                  r_int_active <= 1'b0;
                  r_brk_flag   <= 1'b1;
               end
            end
            default: begin
               r_state      <= RST_PEND;
               r_vector_sel <= VEC_RST;
               r_int_active <= 1'b0;
               r_brk_flag   <= 1'b1;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_irq_sequencer.sv
// tb/tb_irq_sequencer.sv - self-checking bench for irq_sequencer
module tb_irq_sequencer;

   logic       ph1 = 1'b0;
   logic       resetb;
   logic [7:0] mem_data;
   logic [7:0] p;
   logic       first_cycle;
   logic       int_done;
   logic       nmi_b;
   logic       irq_b;
   logic [7:0] data_out;
   logic [1:0] vector_sel;
   logic       int_active;
   logic       brk_flag;

   int checks = 0;
   int errors = 0;

   irq_sequencer #(.SYNC_STAGES(2), .VEC_W(2)) dut (
      .ph1        (ph1),
      .resetb     (resetb),
      .mem_data   (mem_data),
      .p          (p),
      .first_cycle(first_cycle),
      .int_done   (int_done),
      .nmi_b      (nmi_b),
      .irq_b      (irq_b),
      .data_out   (data_out),
      .vector_sel (vector_sel),
      .int_active (int_active),
      .brk_flag   (brk_flag)
   );

   always #5 ph1 = ~ph1;

   typedef struct {
      logic [7:0] data;
      logic [1:0] vec;
      logic       act;
      logic       brk;
      string      name;
   } exp_t;

   typedef struct {
      logic       fc;
      logic       irqb;
      logic       nmib;
      logic [7:0] p;
      logic [7:0] mem;
      logic       dn;
      logic [7:0] ed;
      logic [1:0] ev;
      logic       ea;
      logic       eb;
   } row_t;

   exp_t sb[$];
   row_t tbl[18];

   task automatic push_exp(input logic [7:0] d, input logic [1:0] v, input logic a, input logic b,
                           input string nm);
      exp_t e;
      e.data = d; e.vec = v; e.act = a; e.brk = b; e.name = nm;
      sb.push_back(e);
   endtask

   task automatic compare();
      exp_t e;
      checks++;
      if (sb.size() == 0) begin
         errors++;
         $display("FAIL scoreboard_empty: got nothing expected, want one entry");
      end else begin
         e = sb.pop_front();
         if (data_out !== e.data || vector_sel !== e.vec || int_active !== e.act || brk_flag !== e.brk) begin
            errors++;
            $display("FAIL %s: got data=%h vec=%b act=%b brk=%b, want data=%h vec=%b act=%b brk=%b",
                     e.name, data_out, vector_sel, int_active, brk_flag, e.data, e.vec, e.act, e.brk);
         end
      end
   endtask

   task automatic cyc(input logic fc, input logic irqb, input logic nmib, input logic [7:0] pv,
                      input logic [7:0] mv, input logic dn, input logic [7:0] ed,
                      input logic [1:0] ev, input logic ea, input logic eb, input string nm);
      @(negedge ph1);
      first_cycle = fc; irq_b = irqb; nmi_b = nmib; p = pv; mem_data = mv; int_done = dn;
      push_exp(ed, ev, ea, eb, nm);
      #2;
      compare();
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout, want completion");
      $fatal(1, "watchdog");
   end

   initial begin
      // fc irqb nmib p mem done | data vec act brk
      tbl[0]  = '{1'b0, 1'b1, 1'b1, 8'h00, 8'hA9, 1'b0, 8'hA9, 2'b10, 1'b0, 1'b1};
      tbl[1]  = '{1'b1, 1'b1, 1'b1, 8'h00, 8'hA9, 1'b0, 8'h00, 2'b10, 1'b0, 1'b1};
      tbl[2]  = '{1'b0, 1'b1, 1'b1, 8'h00, 8'h11, 1'b0, 8'h11, 2'b10, 1'b1, 1'b0};
      tbl[3]  = '{1'b0, 1'b1, 1'b1, 8'h00, 8'h22, 1'b1, 8'h22, 2'b10, 1'b1, 1'b0};
      tbl[4]  = '{1'b0, 1'b1, 1'b1, 8'h00, 8'h33, 1'b0, 8'h33, 2'b00, 1'b0, 1'b1};
      tbl[5]  = '{1'b1, 1'b1, 1'b1, 8'h00, 8'hA9, 1'b0, 8'hA9, 2'b00, 1'b0, 1'b1};
      tbl[6]  = '{1'b0, 1'b1, 1'b1, 8'h00, 8'h44, 1'b1, 8'h44, 2'b00, 1'b0, 1'b1};
      tbl[7]  = '{1'b1, 1'b1, 1'b1, 8'h00, 8'h00, 1'b0, 8'h00, 2'b00, 1'b0, 1'b1};
      tbl[8]  = '{1'b0, 1'b0, 1'b1, 8'h04, 8'h55, 1'b0, 8'h55, 2'b00, 1'b0, 1'b1};
      tbl[9]  = '{1'b0, 1'b0, 1'b1, 8'h04, 8'h56, 1'b0, 8'h56, 2'b00, 1'b0, 1'b1};
      tbl[10] = '{1'b0, 1'b0, 1'b1, 8'h04, 8'h57, 1'b0, 8'h57, 2'b00, 1'b0, 1'b1};
      tbl[11] = '{1'b0, 1'b0, 1'b1, 8'h04, 8'h58, 1'b0, 8'h58, 2'b00, 1'b0, 1'b1};
      tbl[12] = '{1'b1, 1'b0, 1'b1, 8'h04, 8'h66, 1'b0, 8'h66, 2'b00, 1'b0, 1'b1};
      tbl[13] = '{1'b1, 1'b0, 1'b1, 8'h00, 8'h77, 1'b0, 8'h00, 2'b00, 1'b0, 1'b1};
      tbl[14] = '{1'b0, 1'b0, 1'b1, 8'h00, 8'h88, 1'b0, 8'h88, 2'b00, 1'b1, 1'b0};
      tbl[15] = '{1'b0, 1'b1, 1'b1, 8'h00, 8'h99, 1'b1, 8'h99, 2'b00, 1'b1, 1'b0};
      tbl[16] = '{1'b0, 1'b1, 1'b1, 8'h00, 8'h12, 1'b0, 8'h12, 2'b00, 1'b0, 1'b1};
      tbl[17] = '{1'b1, 1'b1, 1'b1, 8'h00, 8'h34, 1'b0, 8'h34, 2'b00, 1'b0, 1'b1};

      resetb = 1'b0; first_cycle = 1'b0; int_done = 1'b0; nmi_b = 1'b1; irq_b = 1'b1;
      p = 8'h00; mem_data = 8'hA9;
      @(negedge ph1); #2;
      push_exp(8'hA9, 2'b10, 1'b0, 1'b1, "reset_state");
      compare();
      @(negedge ph1);
      resetb = 1'b1;

      for (int i = 0; i < 18; i++)
         cyc(tbl[i].fc, tbl[i].irqb, tbl[i].nmib, tbl[i].p, tbl[i].mem, tbl[i].dn,
             tbl[i].ed, tbl[i].ev, tbl[i].ea, tbl[i].eb, $sformatf("tbl%0d", i));

      // NMI latency through the synchroniser, then a held-low nmi_b is serviced once only
      cyc(0, 1, 0, 8'h00, 8'hC1, 0, 8'hC1, 2'b00, 0, 1, "nmi_fall");
      cyc(0, 1, 0, 8'h00, 8'hC2, 0, 8'hC2, 2'b00, 0, 1, "nmi_sync");
      cyc(1, 1, 0, 8'h00, 8'hC3, 0, 8'hC3, 2'b00, 0, 1, "nmi_not_yet");
      cyc(1, 1, 0, 8'h00, 8'hC4, 0, 8'h00, 2'b00, 0, 1, "nmi_inject");
      cyc(0, 1, 0, 8'h00, 8'hC5, 0, 8'hC5, 2'b01, 1, 0, "nmi_active");
      cyc(0, 1, 0, 8'h00, 8'hC6, 1, 8'hC6, 2'b01, 1, 0, "nmi_done");
      cyc(1, 1, 0, 8'h00, 8'hC7, 0, 8'hC7, 2'b00, 0, 1, "nmi_held1");
      cyc(1, 1, 0, 8'h00, 8'hC8, 0, 8'hC8, 2'b00, 0, 1, "nmi_held2");

      // NMI edges during an IRQ sequence merge and pre-empt the still-asserted IRQ
      for (int i = 0; i < 3; i++)
         cyc(0, 0, 1, 8'h00, 8'hD1, 0, 8'hD1, 2'b00, 0, 1, "irq_setup");
      cyc(1, 0, 1, 8'h00, 8'hD4, 0, 8'h00, 2'b00, 0, 1, "irq_inject");
      cyc(0, 0, 0, 8'h00, 8'hD5, 0, 8'hD5, 2'b00, 1, 0, "irq_act_nmi1");
      cyc(0, 0, 0, 8'h00, 8'hD6, 0, 8'hD6, 2'b00, 1, 0, "irq_act_b6");
      cyc(0, 0, 1, 8'h00, 8'hD7, 0, 8'hD7, 2'b00, 1, 0, "irq_act_b7");
      cyc(0, 0, 1, 8'h00, 8'hD8, 0, 8'hD8, 2'b00, 1, 0, "irq_act_b8");
      cyc(0, 0, 0, 8'h00, 8'hD9, 0, 8'hD9, 2'b00, 1, 0, "irq_act_nmi2");
      cyc(0, 0, 0, 8'h00, 8'hDA, 0, 8'hDA, 2'b00, 1, 0, "irq_act_b10");
      cyc(0, 0, 0, 8'h00, 8'hDB, 0, 8'hDB, 2'b00, 1, 0, "irq_act_b11");
      cyc(0, 0, 0, 8'h00, 8'hDC, 1, 8'hDC, 2'b00, 1, 0, "irq_done");
      cyc(1, 0, 0, 8'h00, 8'hE1, 0, 8'h00, 2'b00, 0, 1, "nmi_first_inject");
      cyc(0, 0, 0, 8'h00, 8'hE2, 0, 8'hE2, 2'b01, 1, 0, "nmi_first_vec");
      cyc(0, 0, 0, 8'h00, 8'hE3, 1, 8'hE3, 2'b01, 1, 0, "nmi_first_done");
      cyc(1, 0, 0, 8'h00, 8'hE4, 0, 8'h00, 2'b00, 0, 1, "merge_irq_inject");
      cyc(0, 0, 0, 8'h00, 8'hE5, 0, 8'hE5, 2'b00, 1, 0, "merge_irq_vec");
      cyc(0, 0, 0, 8'h00, 8'hE6, 1, 8'hE6, 2'b00, 1, 0, "merge_irq_done");

      // NMI edge detected in the very cycle of an IRQ injection stays pending
      for (int i = 0; i < 3; i++)
         cyc(0, 0, 1, 8'h00, 8'hF0, 0, 8'hF0, 2'b00, 0, 1, "coin_setup");
      cyc(0, 0, 0, 8'h00, 8'hF4, 0, 8'hF4, 2'b00, 0, 1, "coin_fall");
      cyc(0, 0, 0, 8'h00, 8'hF5, 0, 8'hF5, 2'b00, 0, 1, "coin_sync");
      cyc(1, 0, 0, 8'h00, 8'hF6, 0, 8'h00, 2'b00, 0, 1, "coin_irq_inject");
      cyc(0, 0, 0, 8'h00, 8'hF7, 0, 8'hF7, 2'b00, 1, 0, "coin_irq_vec");
      cyc(0, 1, 0, 8'h00, 8'hF8, 1, 8'hF8, 2'b00, 1, 0, "coin_irq_done");
      cyc(0, 1, 0, 8'h00, 8'hF9, 0, 8'hF9, 2'b00, 0, 1, "coin_idle");
      cyc(1, 1, 0, 8'h00, 8'hFA, 0, 8'h00, 2'b00, 0, 1, "coin_nmi_inject");
      cyc(0, 1, 0, 8'h00, 8'hFB, 0, 8'hFB, 2'b01, 1, 0, "coin_nmi_vec");
      cyc(0, 1, 1, 8'h00, 8'hFC, 0, 8'hFC, 2'b01, 1, 0, "pend_rise1");
      cyc(0, 1, 1, 8'h00, 8'hFD, 0, 8'hFD, 2'b01, 1, 0, "pend_rise2");
      cyc(0, 1, 0, 8'h00, 8'hFE, 0, 8'hFE, 2'b01, 1, 0, "pend_fall");
      cyc(0, 1, 0, 8'h00, 8'hFF, 0, 8'hFF, 2'b01, 1, 0, "pend_sync");
      cyc(0, 1, 0, 8'h00, 8'h5A, 0, 8'h5A, 2'b01, 1, 0, "pend_set");

      // Asynchronous reset mid NMI sequence with another NMI pending
      @(posedge ph1); #2;
      resetb = 1'b0;
      #1;
      push_exp(8'h5A, 2'b10, 1'b0, 1'b1, "reset_async");
      compare();
      @(negedge ph1);
      resetb = 1'b1;
      cyc(0, 1, 0, 8'h00, 8'h61, 0, 8'h61, 2'b10, 0, 1, "post_rst_pend");
      cyc(1, 1, 0, 8'h00, 8'h62, 0, 8'h00, 2'b10, 0, 1, "post_rst_inject");
      cyc(0, 1, 0, 8'h00, 8'h63, 0, 8'h63, 2'b10, 1, 0, "post_rst_active");
      cyc(0, 1, 0, 8'h00, 8'h64, 1, 8'h64, 2'b10, 1, 0, "post_rst_done");
      cyc(1, 1, 0, 8'h00, 8'h65, 0, 8'h65, 2'b00, 0, 1, "post_rst_no_nmi1");
      cyc(1, 1, 0, 8'h00, 8'h66, 0, 8'h66, 2'b00, 0, 1, "post_rst_no_nmi2");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
